// File: rtl/bram_img_loader_if.sv
// Pixel stream (valid/ready) and BRAM port A write bus of the disparity-map loader.
// master = pixel source / BRAM side, slave = the loader itself.
interface bram_img_loader_if #(
   parameter int ADDR_W = 32
) ();
   logic              s_valid;
   logic              s_sof;
   logic [7:0]        s_data;
   logic              s_ready;
   logic              ena;
   logic [3:0]        wea;
   logic [ADDR_W-1:0] addra;
   logic [31:0]       dina;

   modport master (
      output s_valid, s_sof, s_data,
      input  s_ready, ena, wea, addra, dina
   );

   modport slave (
      input  s_valid, s_sof, s_data,
      output s_ready, ena, wea, addra, dina
   );
endinterface

// File: rtl/bram_img_loader.sv
// Packs an 8-bit pixel stream four-per-word into the disparity-map BRAM and
// pulses go/done with the latched window size once a full frame is stored.
module bram_img_loader #(
   parameter int IMG_COLS  = 640,
   parameter int IMG_ROWS  = 480,
   parameter int BASE_ADDR = 0,
   parameter int ADDR_W    = 32
) (
   input  logic             clka,
   input  logic             reset,
   input  logic             start,
   input  logic [2:0]       window,
   input  logic             abort,
   bram_img_loader_if.slave bus,
   output logic             go,
   output logic [2:0]       window_out,
   output logic             busy,
   output logic             done,
   output logic             err
);
   localparam int WORDS  = IMG_ROWS * IMG_COLS / 4;
   localparam int COL_W  = (IMG_COLS > 1) ? $clog2(IMG_COLS) : 1;
   localparam int ROW_W  = (IMG_ROWS > 1) ? $clog2(IMG_ROWS) : 1;
   localparam int WORD_W = (WORDS > 1) ? $clog2(WORDS) : 1;

   typedef enum logic [2:0] {
      S_IDLE     = 3'd0,
      S_WAIT_SOF = 3'd1,
      S_LOAD     = 3'd2,
      S_LAST     = 3'd3,
      S_KICK     = 3'd4
   } state_t;

   state_t              state_q, state_d;
   logic [COL_W-1:0]    col_q, col_d;
   logic [ROW_W-1:0]    row_q, row_d;
   logic [WORD_W-1:0]   word_q, word_d;
   logic [23:0]         pack_q, pack_d;
   logic [2:0]          win_q, win_d;
   logic                err_q, err_d;
   logic                go_q, go_d;
   logic                busy_q, busy_d;
   logic                rdy_q, rdy_d;
   logic                ena_q, ena_d;
   logic [3:0]          wea_q, wea_d;
   logic [ADDR_W-1:0]   addra_q, addra_d;
   logic [31:0]         dina_q, dina_d;
   logic                beat_s;

   function automatic logic window_legal(input logic [2:0] w);
      case (w)
         3'b011, 3'b101, 3'b111: window_legal = 1'b1;
         default:                window_legal = 1'b0;
      endcase
   endfunction

   assign beat_s = bus.s_valid & rdy_q;

   // Next state, counters, packing and the one-deep write stage.
   always_comb begin
      state_d = state_q;
      col_d   = col_q;
      row_d   = row_q;
      word_d  = word_q;
      pack_d  = pack_q;
      win_d   = win_q;
      err_d   = err_q;
      ena_d   = 1'b0;
      wea_d   = 4'h0;
      addra_d = '0;
      dina_d  = 32'h0000_0000;
      if (abort) begin
         state_d = S_IDLE;
         col_d   = '0;
         row_d   = '0;
         word_d  = '0;
         pack_d  = 24'h00_0000;
      end else begin
         case (state_q)
            S_IDLE: begin
               if (start && window_legal(window)) begin
                  win_d   = window;
                  err_d   = 1'b0;
                  col_d   = '0;
                  row_d   = '0;
                  word_d  = '0;
                  pack_d  = 24'h00_0000;
                  state_d = S_WAIT_SOF;
               end else if (start) begin
                  err_d = 1'b1;
               end else begin
                  state_d = S_IDLE;
               end
            end
            S_WAIT_SOF: begin
               if (beat_s && bus.s_sof) begin
                  pack_d  = {16'h0000, bus.s_data};
                  col_d   = COL_W'(1);
                  row_d   = '0;
                  word_d  = '0;
                  state_d = S_LOAD;
               end else begin
                  state_d = S_WAIT_SOF;
               end
            end
            S_LOAD: begin
               // A stray start-of-frame resyncs: partial word dropped, beat becomes pixel 0.
               if (beat_s && bus.s_sof) begin
                  err_d  = 1'b1;
                  pack_d = {16'h0000, bus.s_data};
                  col_d  = COL_W'(1);
                  row_d  = '0;
                  word_d = '0;
               end else if (beat_s) begin
                  case (col_q[1:0])
                     2'd0: pack_d[7:0]   = bus.s_data;
                     2'd1: pack_d[15:8]  = bus.s_data;
                     2'd2: pack_d[23:16] = bus.s_data;
                     2'd3: begin
                        ena_d   = 1'b1;
                        wea_d   = 4'hF;
                        addra_d = ADDR_W'(BASE_ADDR) + ADDR_W'(word_q);
                        dina_d  = {bus.s_data, pack_q};
                        if (word_q == WORD_W'(WORDS - 1)) begin
                           word_d  = '0;
                           state_d = S_LAST;
                        end else begin
                           word_d = word_q + WORD_W'(1);
                        end
                     end
                     default: pack_d = pack_q;
                  endcase
                  if (col_q == COL_W'(IMG_COLS - 1)) begin
                     col_d = '0;
                     if (row_q == ROW_W'(IMG_ROWS - 1)) begin
                        row_d = '0;
                     end else begin
                        row_d = row_q + ROW_W'(1);
                     end
                  end else begin
                     col_d = col_q + COL_W'(1);
                  end
               end else begin
                  state_d = S_LOAD;
               end
            end
            S_LAST:  state_d = S_KICK;
            S_KICK:  state_d = S_IDLE;
            default: state_d = S_IDLE;
         endcase
      end
      rdy_d  = (state_d == S_WAIT_SOF) || (state_d == S_LOAD);
      busy_d = (state_d != S_IDLE);
      go_d   = (state_d == S_KICK);
   end

   // State, counters and registered outputs; reset clears everything at once.
   always_ff @(posedge clka or negedge reset) begin
      if (!reset) begin
         state_q <= S_IDLE;
         col_q   <= '0;
         row_q   <= '0;
         word_q  <= '0;
         pack_q  <= 24'h00_0000;
         win_q   <= 3'b000;
         err_q   <= 1'b0;
         go_q    <= 1'b0;
         busy_q  <= 1'b0;
         rdy_q   <= 1'b0;
         ena_q   <= 1'b0;
         wea_q   <= 4'h0;
         addra_q <= '0;
         dina_q  <= 32'h0000_0000;
      end else begin
         state_q <= state_d;
         col_q   <= col_d;
         row_q   <= row_d;
         word_q  <= word_d;
         pack_q  <= pack_d;
         win_q   <= win_d;
         err_q   <= err_d;
         go_q    <= go_d;
         busy_q  <= busy_d;
         rdy_q   <= rdy_d;
         ena_q   <= ena_d;
         wea_q   <= wea_d;
         addra_q <= addra_d;
         dina_q  <= dina_d;
      end
   end

   assign bus.s_ready = rdy_q;
   assign bus.ena     = ena_q;
   assign bus.wea     = wea_q;
   assign bus.addra   = addra_q;
   assign bus.dina    = dina_q;
   assign go          = go_q;
   assign done        = go_q;
   assign busy        = busy_q;
   assign err         = err_q;
   assign window_out  = win_q;
endmodule

// File: tb/tb_bram_img_loader.sv
// Bench for bram_img_loader on an 8x2 image at word base 16: start-vector table,
// directed frames and random frames checked against a pixel-list model.
module tb_bram_img_loader;
   localparam int COLS = 8;
   localparam int ROWS = 2;
   localparam int BASE = 16;
   localparam int AW   = 32;
   localparam int NPIX = COLS * ROWS;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       start = 1'b0;
   logic       abort = 1'b0;
   logic [2:0] window = 3'b000;
   logic       go, busy, done, err;
   logic [2:0] window_out;

   bram_img_loader_if #(.ADDR_W(AW)) bus ();

   bram_img_loader #(
      .IMG_COLS(COLS), .IMG_ROWS(ROWS), .BASE_ADDR(BASE), .ADDR_W(AW)
   ) dut (
      .clka(clk), .reset(rst_n), .start(start), .window(window), .abort(abort),
      .bus(bus), .go(go), .window_out(window_out), .busy(busy), .done(done), .err(err)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   typedef struct { logic [AW-1:0] addr; logic [31:0] data; int cyc; } wr_t;
   typedef struct { logic sof; logic [7:0] data; int edge_n; } beat_t;
   typedef struct {
      logic start; logic [2:0] win; logic abort;
      logic exp_err; logic exp_busy; logic [2:0] exp_win;
   } vec_t;

   wr_t   got_q[$];
   wr_t   exp_q[$];
   int    go_cyc_q[$];
   beat_t beats[$];
   int    viol = 0;
   int    n_checks = 0;
   int    n_errors = 0;

   // Write / go monitor plus bus-rule watch, sampled mid-cycle.
   always @(negedge clk) begin
      wr_t w;
      if (bus.ena === 1'b1) begin
         w.addr = bus.addra; w.data = bus.dina; w.cyc = cyc;
         got_q.push_back(w);
      end
      if (go === 1'b1) go_cyc_q.push_back(cyc);
      if ((bus.ena === 1'b1 && bus.wea !== 4'hF) || (bus.ena !== 1'b1 && bus.wea !== 4'h0) ||
          (go !== done))
         viol++;
   end

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic drive_beat(input logic sof, input logic [7:0] d);
      beat_t b;
      bus.s_valid = 1'b1; bus.s_sof = sof; bus.s_data = d;
      b.sof = sof; b.data = d; b.edge_n = cyc + 1;
      beats.push_back(b);
      @(posedge clk); #1;
      bus.s_valid = 1'b0; bus.s_sof = 1'b0;
   endtask

   // Idle cycles with junk on s_sof/s_data that must be ignored while s_valid=0.
   task automatic gap_cycles(input int mode, input bit not_first);
      int g;
      g = (mode == 1) ? (not_first ? 1 : 0) : (mode == 2) ? int'($urandom_range(0, 2)) : 0;
      for (int k = 0; k < g; k++) begin
         bus.s_valid = 1'b0; bus.s_sof = 1'($urandom_range(0, 1)); bus.s_data = 8'($urandom);
         @(posedge clk); #1;
      end
      bus.s_sof = 1'b0;
   endtask

   // Model: pixels since the last SOF, one word per 4, address from (row, col).
   task automatic build_expect(output int last_edge, output logic exp_err);
      logic [7:0] cur[$];
      bit started;
      started = 1'b0; last_edge = -1; exp_err = 1'b0;
      exp_q.delete();
      foreach (beats[i]) begin
         if (!started) begin
            if (!beats[i].sof) continue;
            started = 1'b1;
         end else if (beats[i].sof) begin
            exp_err = 1'b1;
            cur.delete();
         end
         cur.push_back(beats[i].data);
         if (cur.size() % 4 == 0) begin
            int  p;
            wr_t w;
            p = cur.size() - 4;
            w.addr = AW'(BASE + (p / COLS) * (COLS / 4) + (p % COLS) / 4);
            w.data = {cur[p+3], cur[p+2], cur[p+1], cur[p]};
            w.cyc  = beats[i].edge_n;
            exp_q.push_back(w);
            if (cur.size() == NPIX) last_edge = beats[i].edge_n;
         end
      end
   endtask

   task automatic run_frame(input string tag, input logic [2:0] win, input int junk, input int inj,
                            input int gap, input int abort_after, input bit seq_data);
      int   base, go0, viol0, nfr, last_edge, seen, ng;
      logic exp_err, sof;
      logic [7:0] d;
      beats.delete();
      base = got_q.size(); go0 = go_cyc_q.size(); viol0 = viol;
      window = win; start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      check({tag, "_armed_ready"}, bus.s_ready, 1);
      check({tag, "_armed_busy"}, busy, 1);
      check({tag, "_armed_err"}, err, 0);
      for (int j = 0; j < junk; j++) begin
         gap_cycles(gap, j > 0);
         drive_beat(1'b0, 8'($urandom));
      end
      nfr = (abort_after > 0) ? abort_after : inj + NPIX;
      for (int j = 0; j < nfr; j++) begin
         gap_cycles(gap, (junk + j) > 0);
         sof = (j == 0) || (inj > 0 && j == inj);
         d = seq_data ? 8'(j - ((inj > 0 && j >= inj) ? inj : 0)) : 8'($urandom);
         drive_beat(sof, d);
      end
      build_expect(last_edge, exp_err);
      if (abort_after > 0) begin
         abort = 1'b1;
         @(posedge clk); #1;
         abort = 1'b0;
         check({tag, "_abort_busy"}, busy, 0);
         check({tag, "_abort_ready"}, bus.s_ready, 0);
         repeat (3) @(posedge clk);
         #1;
         check({tag, "_abort_no_go"}, go_cyc_q.size() - go0, 0);
      end else begin
         seen = 0;
         for (int t = 0; t < 40; t++) begin
            @(negedge clk);
            if (go === 1'b1) begin seen = 1; break; end
         end
         check({tag, "_go_seen"}, seen, 1);
         if (seen == 1) begin
            check({tag, "_go_cycle"}, cyc, last_edge + 1);
            check({tag, "_done_with_go"}, done, 1);
            check({tag, "_window_out"}, window_out, win);
            check({tag, "_busy_at_go"}, busy, 1);
            @(negedge clk);
            check({tag, "_busy_after"}, busy, 0);
            check({tag, "_go_one_cycle"}, go, 0);
         end
         repeat (2) @(negedge clk);
         check({tag, "_go_count"}, go_cyc_q.size() - go0, 1);
         @(posedge clk); #1;
      end
      ng = got_q.size() - base;
      check({tag, "_write_count"}, ng, exp_q.size());
      for (int k = 0; k < exp_q.size() && k < ng; k++) begin
         check($sformatf("%s_addr%0d", tag, k), got_q[base+k].addr, exp_q[k].addr);
         check($sformatf("%s_data%0d", tag, k), got_q[base+k].data, exp_q[k].data);
         check($sformatf("%s_wcyc%0d", tag, k), got_q[base+k].cyc, exp_q[k].cyc);
      end
      check({tag, "_err_final"}, err, exp_err);
      check({tag, "_bus_rules"}, viol - viol0, 0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      vec_t       vt[10];
      logic [2:0] legal_w[3];
      int         b0, n0;
      legal_w = '{3'b011, 3'b101, 3'b111};
      vt[0] = '{1'b1, 3'b100, 1'b0, 1'b1, 1'b0, 3'b000};
      vt[1] = '{1'b1, 3'b011, 1'b0, 1'b0, 1'b1, 3'b011};
      vt[2] = '{1'b1, 3'b000, 1'b0, 1'b1, 1'b0, 3'b011};
      vt[3] = '{1'b1, 3'b111, 1'b0, 1'b0, 1'b1, 3'b111};
      vt[4] = '{1'b1, 3'b110, 1'b0, 1'b1, 1'b0, 3'b111};
      vt[5] = '{1'b0, 3'b101, 1'b0, 1'b1, 1'b0, 3'b111};
      vt[6] = '{1'b1, 3'b101, 1'b0, 1'b0, 1'b1, 3'b101};
      vt[7] = '{1'b1, 3'b001, 1'b0, 1'b1, 1'b0, 3'b101};
      vt[8] = '{1'b1, 3'b011, 1'b1, 1'b1, 1'b0, 3'b101};
      vt[9] = '{1'b1, 3'b010, 1'b0, 1'b1, 1'b0, 3'b101};

      bus.s_valid = 1'b0; bus.s_sof = 1'b0; bus.s_data = 8'h00;
      #12;
      check("reset_busy", busy, 0);
      check("reset_ready", bus.s_ready, 0);
      check("reset_ena", bus.ena, 0);
      check("reset_go", go, 0);
      check("reset_err", err, 0);
      check("reset_window_out", window_out, 0);
      rst_n = 1'b1;
      @(posedge clk); #1;

      n0 = got_q.size();
      for (int i = 0; i < 10; i++) begin
         start = vt[i].start; window = vt[i].win; abort = vt[i].abort;
         @(posedge clk); #1;
         start = 1'b0; abort = 1'b0;
         check($sformatf("vec%0d_err", i), err, vt[i].exp_err);
         check($sformatf("vec%0d_busy", i), busy, vt[i].exp_busy);
         check($sformatf("vec%0d_ready", i), bus.s_ready, vt[i].exp_busy);
         check($sformatf("vec%0d_window_out", i), window_out, vt[i].exp_win);
         if (vt[i].exp_busy) begin
            abort = 1'b1;
            @(posedge clk); #1;
            abort = 1'b0;
            check($sformatf("vec%0d_abort_idle", i), busy, 0);
         end
      end
      check("vec_no_writes", got_q.size() - n0, 0);

      run_frame("legal_after_illegal", 3'b011, 0, 0, 0, 0, 1'b1);
      b0 = got_q.size();
      run_frame("basic", 3'b101, 0, 0, 0, 0, 1'b1);
      if (got_q.size() >= b0 + 4) begin
         check("basic_first_word", got_q[b0].data, 32'h0302_0100);
         check("basic_last_word", got_q[b0+3].data, 32'h0F0E_0D0C);
         check("basic_last_addr", got_q[b0+3].addr, 32'd19);
      end
      run_frame("toggle_valid", 3'b101, 0, 0, 1, 0, 1'b1);
      run_frame("junk_before_sof", 3'b111, 3, 0, 0, 0, 1'b1);
      run_frame("sof_on_6th", 3'b011, 0, 5, 0, 0, 1'b1);
      run_frame("abort_after_9", 3'b101, 0, 0, 0, 9, 1'b1);
      run_frame("after_abort", 3'b111, 0, 0, 0, 0, 1'b0);

      for (int r = 0; r < 10; r++) begin
         int inj, ab;
         inj = ($urandom_range(0, 2) == 0) ? int'($urandom_range(1, 15)) : 0;
         ab  = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 15)) : 0;
         run_frame($sformatf("rand%0d", r), legal_w[$urandom_range(0, 2)],
                   int'($urandom_range(0, 3)), inj, 2, ab, 1'b0);
      end

      // Reset while a write is on the bus, with err also set by a resync.
      beats.delete();
      window = 3'b111; start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      for (int j = 0; j < 5; j++) drive_beat(j == 0, 8'(j));
      drive_beat(1'b1, 8'hA0);
      for (int j = 0; j < 3; j++) drive_beat(1'b0, 8'(8'hA1 + j));
      check("pre_reset_ena", bus.ena, 1);
      check("pre_reset_err", err, 1);
      check("pre_reset_busy", busy, 1);
      #2 rst_n = 1'b0;
      #1;
      check("async_reset_ena", bus.ena, 0);
      check("async_reset_wea", bus.wea, 0);
      check("async_reset_go", go, 0);
      check("async_reset_busy", busy, 0);
      check("async_reset_err", err, 0);
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk); #1;
      check("post_reset_ready", bus.s_ready, 0);
      check("post_reset_busy", busy, 0);
      check("post_reset_window_out", window_out, 0);

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end
endmodule
